ps2_mouse_packet_tracker: RTL and testbench
===========================================

Name: ps2_mouse_packet_tracker

Overview:
Parametrised packet layer that sits between the PS/2 byte receiver and the bus-facing mouse peripheral. It assembles 3-byte standard packets or 4-byte wheel packets from received bytes. It validates framing, resynchronises on corruption or inter-byte timeout, and accumulates an absolute, saturating X/Y cursor position plus a wheel count. It also raises a level interrupt that is held until the processor acknowledges it.

Parameters:
LIMIT_X, 160, X range; position clamps to 0..LIMIT_X-1
LIMIT_Y, 120, Y range; position clamps to 0..LIMIT_Y-1
POS_W, 8, width of position outputs; must satisfy 2^POS_W >= max(LIMIT_X, LIMIT_Y)
PACKET_BYTES, 3, 3 = standard packet; 4 = wheel packet (byte 3 carries Z)
TIMEOUT_CYCLES, 2000000, maximum CLK cycles between bytes of one packet

Ports:
CLK  in  1  system clock (single clock domain)
RESET  in  1  asynchronous, active-high reset
BYTE_READY  in  1  one-cycle strobe; a received byte is valid
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  00 = ok; nonzero = parity or framing error on that byte
INTERRUPT_ACK  in  1  one-cycle strobe from the bus; clears SEND_INTERRUPT
MOUSE_X  out  POS_W  absolute X position
MOUSE_Y  out  POS_W  absolute Y position; 0 = top
MOUSE_Z  out  8  wheel accumulator, two's complement, wraps
MOUSE_BUTTONS  out  3  {middle, right, left}
SEND_INTERRUPT  out  1  new packet applied; held high until acknowledged
SYNC_ERR_COUNT  out  8  count of discarded packets; saturates at 255
current_state  out  3  state encoding, for debug

Behaviour:
- Reset values:
  - MOUSE_X = LIMIT_X/2 and MOUSE_Y = LIMIT_Y/2 (integer division).
  - MOUSE_Z = 0, MOUSE_BUTTONS = 0, SEND_INTERRUPT = 0, SYNC_ERR_COUNT = 0, state = S_B0, timeout counter = 0.
- Reset mid-packet discards all partial bytes.
- States: S_B0, S_B1, S_B2, S_B3, S_UPDATE. S_B3 is used only when PACKET_BYTES = 4.
- S_B0:
  - On BYTE_READY with error code 00 and BYTE_READ[3] = 1: store the byte as status, go to S_B1.
  - On BYTE_READY with bit 3 = 0 or a nonzero error code: discard the byte, increment SYNC_ERR_COUNT, stay in S_B0.
- S_B1 and S_B2:
  - On BYTE_READY with error code 00: store DX (from S_B1) or DY (from S_B2), then advance.
  - S_B2 advances to S_B3 if PACKET_BYTES = 4, otherwise to S_UPDATE.
- S_B3: on BYTE_READY with error code 00, store Z, go to S_UPDATE.
- Errors in S_B1..S_B3:
  - A nonzero error code discards the packet, increments the count, returns to S_B0.
  - A timeout counter clears on every BYTE_READY and increments in these states.
  - When the counter reaches TIMEOUT_CYCLES without a byte: discard the packet, increment the count, return to S_B0.
  - The counter is held at 0 while in S_B0.
- S_UPDATE lasts one cycle and always returns to S_B0. A BYTE_READY arriving during S_UPDATE is processed as a byte 0 candidate.
- Latency: outputs and SEND_INTERRUPT change at the clock edge ending S_UPDATE. They are visible 2 cycles after the cycle in which the final BYTE_READY was high.
- X/Y arithmetic:
  - dx = signed 9-bit {status[4], DX}; dy = signed 9-bit {status[5], DY}.
  - If status[6] (X overflow) is set, dx = 0. If status[7] (Y overflow) is set, dy = 0.
  - Sums use POS_W+2-bit signed math.
  - X_new = clamp(X + dx, 0, LIMIT_X-1).
  - Y_new = clamp(Y - dy, 0, LIMIT_Y-1). The subtraction is because PS/2 +Y is up.
- Wheel: MOUSE_Z += sign-extended Z[3:0], modulo 256. When PACKET_BYTES = 3, MOUSE_Z is constant 0.
- MOUSE_BUTTONS = {status[2], status[1], status[0]}, updated in S_UPDATE.
- Interrupt:
  - SEND_INTERRUPT is set in S_UPDATE and cleared by INTERRUPT_ACK.
  - If set and ack occur in the same cycle, set wins.
  - A new packet while an interrupt is pending overwrites the outputs; SEND_INTERRUPT stays high.
- SYNC_ERR_COUNT is never cleared except by RESET.

Test Plan:
1. Reset, then bytes 0x08, 0x05, 0x03 (error 00) -> 2 cycles later MOUSE_X = 85, MOUSE_Y = 57, buttons = 0, SEND_INTERRUPT = 1. INTERRUPT_ACK -> 0 next cycle.
2. Clamp: X = 85, packet 0x18, 0x9C (dx = -100) -> MOUSE_X = 0. Then packet 0x08, 0x7F twice -> MOUSE_X = 159 (not 254).
3. Resync: bytes 0x00, 0x08, 0x02, 0x00 -> first byte dropped, SYNC_ERR_COUNT = 1, the packet starting at 0x08 is applied (X +2). Byte 2 with error code 01 -> packet dropped, count = 2, no interrupt.
4. Timeout with TIMEOUT_CYCLES = 50: send 0x08, 0x04, then 60-cycle gap, then 0x08, 0x01, 0x01 -> count +1, only the second packet applied (X +1, Y -1).
5. PACKET_BYTES = 4: packet 0x0C, 0x00, 0x00, 0x0F -> MOUSE_Z = 0xFF, buttons = 3'b100. Overflow status 0x48 with DX = 0x50 -> X unchanged.
6. Set/ack collision: INTERRUPT_ACK high in the same cycle as S_UPDATE -> SEND_INTERRUPT = 1. Assert RESET mid-packet after 2 bytes -> all outputs at reset values, next valid packet applied normally.

Source files
------------

// File: rtl/ps2_mouse_packet_tracker_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_packet_tracker_if
//   Groups the byte-receiver side and the bus-facing side of the PS/2 mouse
//   packet tracker into one bundle.
//
//   Receiver side : byte_ready (1-cycle strobe), byte_read[7:0],
//                   byte_error_code[1:0] (00 = clean byte)
//   Bus side      : interrupt_ack (1-cycle strobe), mouse_x/mouse_y[POS_W-1:0],
//                   mouse_z[7:0], mouse_buttons[2:0] {middle,right,left},
//                   send_interrupt, sync_err_count[7:0], current_state[2:0]
//
//   master : whoever feeds bytes and acknowledges interrupts
//   slave  : the packet tracker itself
// ----------------------------------------------------------------------------
interface ps2_mouse_packet_tracker_if #(
  parameter int POS_W = 8
) ();

  logic             byte_ready;
  logic [7:0]       byte_read;
  logic [1:0]       byte_error_code;
  logic             interrupt_ack;

  logic [POS_W-1:0] mouse_x;
  logic [POS_W-1:0] mouse_y;
  logic [7:0]       mouse_z;
  logic [2:0]       mouse_buttons;
  logic             send_interrupt;
  logic [7:0]       sync_err_count;
  logic [2:0]       current_state;

  modport master (
    output byte_ready, byte_read, byte_error_code, interrupt_ack,
    input  mouse_x, mouse_y, mouse_z, mouse_buttons,
           send_interrupt, sync_err_count, current_state
  );

  modport slave (
    input  byte_ready, byte_read, byte_error_code, interrupt_ack,
    output mouse_x, mouse_y, mouse_z, mouse_buttons,
           send_interrupt, sync_err_count, current_state
  );

endinterface

// File: rtl/ps2_mouse_packet_tracker.sv
// ----------------------------------------------------------------------------
// ps2_mouse_packet_tracker
//   Assembles 3-byte (standard) or 4-byte (wheel) PS/2 mouse packets from a
//   byte receiver, drops corrupted or stalled packets, and keeps an absolute,
//   clamped X/Y cursor, a wrapping wheel count and the button state. A level
//   interrupt is raised on every applied packet and held until acknowledged.
//
//   Ports:
//     clk  - system clock
//     rst  - asynchronous, active-high reset
//     bus  - slave side of ps2_mouse_packet_tracker_if (byte input, position,
//            wheel, buttons, interrupt, sync error count, debug state)
// ----------------------------------------------------------------------------
module ps2_mouse_packet_tracker #(
  parameter int LIMIT_X        = 160,
  parameter int LIMIT_Y        = 120,
  parameter int POS_W          = 8,
  parameter int PACKET_BYTES   = 3,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk,
  input  logic                     rst,
  ps2_mouse_packet_tracker_if.slave bus
);

  // Signed width used for position arithmetic: room for sign plus overshoot.
  localparam int SW = POS_W + 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [POS_W-1:0]        X_RESET   = POS_W'(LIMIT_X / 2);
  localparam logic [POS_W-1:0]        Y_RESET   = POS_W'(LIMIT_Y / 2);
  localparam logic [POS_W-1:0]        X_MAX_U   = POS_W'(LIMIT_X - 1);
  localparam logic [POS_W-1:0]        Y_MAX_U   = POS_W'(LIMIT_Y - 1);
  localparam logic signed [SW-1:0]    X_MAX_S   = SW'(LIMIT_X - 1);
  localparam logic signed [SW-1:0]    Y_MAX_S   = SW'(LIMIT_Y - 1);
  localparam logic [TW-1:0]           TOUT_LAST = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_B0     = 3'd0,
    S_B1     = 3'd1,
    S_B2     = 3'd2,
    S_B3     = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Captured packet fields. Bit 3 of the status byte is only a framing marker,
  // so it is checked on arrival but never stored.
  logic [2:0] btn_q;
  logic       sign_x_q;
  logic       sign_y_q;
  logic       ovf_x_q;
  logic       ovf_y_q;
  logic [7:0] dx_q;
  logic [7:0] dy_q;
  logic [3:0] z_q;

  logic [TW-1:0]    timeout_cnt;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [7:0]       wheel;
  logic [2:0]       buttons;
  logic             irq;
  logic [7:0]       err_count;

  logic byte_ok;
  logic byte_bad;
  logic in_packet;
  logic timed_out;

  logic load_status;
  logic load_dx;
  logic load_dy;
  logic load_z;
  logic drop;
  logic apply;

  logic signed [8:0]    dx9;
  logic signed [8:0]    dy9;
  logic signed [SW-1:0] x_sum;
  logic signed [SW-1:0] y_sum;
  logic [POS_W-1:0]     x_new;
  logic [POS_W-1:0]     y_new;
  logic [7:0]           z_step;

  assign byte_ok   = bus.byte_ready && (bus.byte_error_code == 2'b00);
  assign byte_bad  = bus.byte_ready && (bus.byte_error_code != 2'b00);
  assign in_packet = (state == S_B1) || (state == S_B2) || (state == S_B3);
  // A byte arriving in the very cycle the limit is hit still counts as on time.
  assign timed_out = in_packet && !bus.byte_ready && (timeout_cnt >= TOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_B0;
    end else begin
      state <= next_state;
    end
  end

  // S_UPDATE doubles as a byte-0 slot so a status byte arriving right behind
  // the last byte of the previous packet is not lost.
  always_comb begin
    next_state  = state;
    load_status = 1'b0;
    load_dx     = 1'b0;
    load_dy     = 1'b0;
    load_z      = 1'b0;
    drop        = 1'b0;
    apply       = 1'b0;
    case (state)
      S_B0, S_UPDATE: begin
        apply      = (state == S_UPDATE);
        next_state = S_B0;
        if (byte_ok && bus.byte_read[3]) begin
          load_status = 1'b1;
          next_state  = S_B1;
        end else if (bus.byte_ready) begin
          drop = 1'b1;
        end
      end
      S_B1: begin
        if (byte_ok) begin
          load_dx    = 1'b1;
          next_state = S_B2;
        end else if (byte_bad || timed_out) begin
          drop       = 1'b1;
          next_state = S_B0;
        end
      end
      S_B2: begin
        if (byte_ok) begin
          load_dy    = 1'b1;
          next_state = (PACKET_BYTES == 4) ? S_B3 : S_UPDATE;
        end else if (byte_bad || timed_out) begin
          drop       = 1'b1;
          next_state = S_B0;
        end
      end
      S_B3: begin
        if (byte_ok) begin
          load_z     = 1'b1;
          next_state = S_UPDATE;
        end else if (byte_bad || timed_out) begin
          drop       = 1'b1;
          next_state = S_B0;
        end
      end
      default: begin
        next_state = S_B0;
      end
    endcase
  end

  // Inter-byte watchdog: runs only while part of a packet is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (in_packet && !bus.byte_ready && !timed_out) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end else begin
      timeout_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q    <= '0;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      ovf_x_q  <= 1'b0;
      ovf_y_q  <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      z_q      <= '0;
    end else begin
      if (load_status) begin
        btn_q    <= bus.byte_read[2:0];
        sign_x_q <= bus.byte_read[4];
        sign_y_q <= bus.byte_read[5];
        ovf_x_q  <= bus.byte_read[6];
        ovf_y_q  <= bus.byte_read[7];
      end
      if (load_dx) dx_q <= bus.byte_read;
      if (load_dy) dy_q <= bus.byte_read;
      if (load_z)  z_q  <= bus.byte_read[3:0];
    end
  end

  // Position update. Overflowed axes contribute no motion; PS/2 +Y points up
  // while our Y grows downward, hence the subtraction.
  always_comb begin
    dx9    = ovf_x_q ? 9'sd0 : $signed({sign_x_q, dx_q});
    dy9    = ovf_y_q ? 9'sd0 : $signed({sign_y_q, dy_q});
    x_sum  = $signed({2'b00, pos_x}) + SW'(dx9);
    y_sum  = $signed({2'b00, pos_y}) - SW'(dy9);
    z_step = {{4{z_q[3]}}, z_q};

    if (x_sum[SW-1]) begin
      x_new = '0;
    end else if (x_sum > X_MAX_S) begin
      x_new = X_MAX_U;
    end else begin
      x_new = x_sum[POS_W-1:0];
    end

    if (y_sum[SW-1]) begin
      y_new = '0;
    end else if (y_sum > Y_MAX_S) begin
      y_new = Y_MAX_U;
    end else begin
      y_new = y_sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x   <= X_RESET;
      pos_y   <= Y_RESET;
      wheel   <= '0;
      buttons <= '0;
    end else if (apply) begin
      pos_x   <= x_new;
      pos_y   <= y_new;
      buttons <= btn_q;
      if (PACKET_BYTES == 4) begin
        wheel <= wheel + z_step;
      end
    end
  end

  // Setting the interrupt takes priority over a simultaneous acknowledge so a
  // fresh packet is never silently swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (apply) begin
      irq <= 1'b1;
    end else if (bus.interrupt_ack) begin
      irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (drop && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign bus.mouse_x        = pos_x;
  assign bus.mouse_y        = pos_y;
  assign bus.mouse_z        = wheel;
  assign bus.mouse_buttons  = buttons;
  assign bus.send_interrupt = irq;
  assign bus.sync_err_count = err_count;
  assign bus.current_state  = state;

endmodule

// File: tb/tb_ps2_mouse_packet_tracker.sv
// ----------------------------------------------------------------------------
// tb_ps2_mouse_packet_tracker
//   Drives a 3-byte instance (dut3) and a 4-byte wheel instance (dut4) with a
//   short inter-byte timeout, and compares both against a packet-level model
//   that buffers bytes in a small array and applies whole packets with plain
//   integer arithmetic.
// ----------------------------------------------------------------------------
module tb_ps2_mouse_packet_tracker;

  localparam int LX = 160;
  localparam int LY = 120;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   n_asserts = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ps2_mouse_packet_tracker_if #(.POS_W(8)) bus3 ();
  ps2_mouse_packet_tracker_if #(.POS_W(8)) bus4 ();

  ps2_mouse_packet_tracker #(
    .LIMIT_X(LX), .LIMIT_Y(LY), .POS_W(8), .PACKET_BYTES(3), .TIMEOUT_CYCLES(TO)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  ps2_mouse_packet_tracker #(
    .LIMIT_X(LX), .LIMIT_Y(LY), .POS_W(8), .PACKET_BYTES(4), .TIMEOUT_CYCLES(TO)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  // Reference model state, index 0 = 3-byte instance, 1 = 4-byte instance.
  int         m_x[2];
  int         m_y[2];
  int         m_z[2];
  int         m_btn[2];
  int         m_irq[2];
  int         m_err[2];
  int         m_cnt[2];
  int         last_e[2];
  logic [7:0] m_buf[2][4];

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int nbytes(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = LX / 2;
      m_y[i] = LY / 2;
      m_z[i] = 0;
      m_btn[i] = 0;
      m_irq[i] = 0;
      m_err[i] = 0;
      m_cnt[i] = 0;
      last_e[i] = 0;
    end
  endtask

  task automatic bump_err(input int i);
    if (m_err[i] < 255) m_err[i] = m_err[i] + 1;
  endtask

  // A held partial packet dies once more than TO cycles pass with no byte.
  task automatic model_flush(input int i, input int e_now);
    if (m_cnt[i] > 0 && (e_now - last_e[i]) >= TO + 1) begin
      m_cnt[i] = 0;
      bump_err(i);
    end
  endtask

  task automatic model_apply(input int i);
    logic [7:0] st;
    int dx;
    int dy;
    int zs;
    st = m_buf[i][0];
    dx = st[6] ? 0 : (int'(m_buf[i][1]) - (st[4] ? 256 : 0));
    dy = st[7] ? 0 : (int'(m_buf[i][2]) - (st[5] ? 256 : 0));
    m_x[i] = clampi(m_x[i] + dx, LX - 1);
    m_y[i] = clampi(m_y[i] - dy, LY - 1);
    m_btn[i] = int'(st[2:0]);
    if (nbytes(i) == 4) begin
      zs = int'(m_buf[i][3][3:0]);
      if (zs >= 8) zs = zs - 16;
      m_z[i] = (m_z[i] + zs) & 255;
    end
    m_irq[i] = 1;
    m_cnt[i] = 0;
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input logic [1:0] e, input int e_now);
    model_flush(i, e_now - 1);
    last_e[i] = e_now;
    if (e != 2'b00) begin
      m_cnt[i] = 0;
      bump_err(i);
    end else if (m_cnt[i] == 0) begin
      if (b[3]) begin
        m_buf[i][0] = b;
        m_cnt[i] = 1;
      end else begin
        bump_err(i);
      end
    end else begin
      m_buf[i][m_cnt[i]] = b;
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] == nbytes(i)) model_apply(i);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One byte to the instances selected by mask, followed by gap idle cycles.
  task automatic apply_stimulus(input logic [1:0] mask, input logic [7:0] b,
                                input logic [1:0] e, input int gap);
    bus3.byte_ready      = mask[0];
    bus3.byte_read       = b;
    bus3.byte_error_code = e;
    bus4.byte_ready      = mask[1];
    bus4.byte_read       = b;
    bus4.byte_error_code = e;
    @(posedge clk);
    #1;
    bus3.byte_ready = 1'b0;
    bus4.byte_ready = 1'b0;
    if (mask[0]) model_byte(0, b, e, edge_cnt);
    if (mask[1]) model_byte(1, b, e, edge_cnt);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input logic [1:0] mask, input string tag);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        model_flush(i, edge_cnt);
        if (i == 0) begin
          check_val({tag, "_x3"},   32'(bus3.mouse_x),        m_x[0]);
          check_val({tag, "_y3"},   32'(bus3.mouse_y),        m_y[0]);
          check_val({tag, "_z3"},   32'(bus3.mouse_z),        m_z[0]);
          check_val({tag, "_btn3"}, 32'(bus3.mouse_buttons),  m_btn[0]);
          check_val({tag, "_irq3"}, 32'(bus3.send_interrupt), m_irq[0]);
          check_val({tag, "_err3"}, 32'(bus3.sync_err_count), m_err[0]);
        end else begin
          check_val({tag, "_x4"},   32'(bus4.mouse_x),        m_x[1]);
          check_val({tag, "_y4"},   32'(bus4.mouse_y),        m_y[1]);
          check_val({tag, "_z4"},   32'(bus4.mouse_z),        m_z[1]);
          check_val({tag, "_btn4"}, 32'(bus4.mouse_buttons),  m_btn[1]);
          check_val({tag, "_irq4"}, 32'(bus4.send_interrupt), m_irq[1]);
          check_val({tag, "_err4"}, 32'(bus4.sync_err_count), m_err[1]);
        end
      end
    end
  endtask

  task automatic do_ack(input logic [1:0] mask);
    bus3.interrupt_ack = mask[0];
    bus4.interrupt_ack = mask[1];
    @(posedge clk);
    #1;
    bus3.interrupt_ack = 1'b0;
    bus4.interrupt_ack = 1'b0;
    if (mask[0]) m_irq[0] = 0;
    if (mask[1]) m_irq[1] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] rb;
    logic [1:0] re;
    int         rg;
    int         r;

    bus3.byte_ready = 1'b0; bus3.byte_read = '0; bus3.byte_error_code = '0; bus3.interrupt_ack = 1'b0;
    bus4.byte_ready = 1'b0; bus4.byte_read = '0; bus4.byte_error_code = '0; bus4.interrupt_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");

    check_output(2'b11, "reset");
    check_val("reset_state3", 32'(bus3.current_state), 0);

    // Basic packet and acknowledge.
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h05, 2'b00, 0);
    apply_stimulus(2'b01, 8'h03, 2'b00, 0);
    check_output(2'b01, "tp1");
    check_val("tp1_x_lit", 32'(bus3.mouse_x), 85);
    check_val("tp1_y_lit", 32'(bus3.mouse_y), 57);
    do_ack(2'b01);
    check_val("tp1_ack", 32'(bus3.send_interrupt), 0);

    // Clamping at both ends of X.
    apply_stimulus(2'b01, 8'h18, 2'b00, 0);
    apply_stimulus(2'b01, 8'h9C, 2'b00, 0);
    apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    check_output(2'b01, "tp2_low");
    check_val("tp2_low_lit", 32'(bus3.mouse_x), 0);
    do_ack(2'b01);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(2'b01, 8'h08, 2'b00, 0);
      apply_stimulus(2'b01, 8'h7F, 2'b00, 0);
      apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    end
    check_output(2'b01, "tp2_high");
    check_val("tp2_high_lit", 32'(bus3.mouse_x), 159);
    do_ack(2'b01);
    apply_stimulus(2'b01, 8'h18, 2'b00, 0);
    apply_stimulus(2'b01, 8'h9C, 2'b00, 0);
    apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    check_output(2'b01, "tp2_back");
    do_ack(2'b01);

    // Resync on a bad first byte, then a packet killed by a receive error.
    apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h02, 2'b00, 0);
    apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    check_output(2'b01, "tp3_resync");
    check_val("tp3_x_lit", 32'(bus3.mouse_x), 61);
    check_val("tp3_err_lit", 32'(bus3.sync_err_count), 1);
    do_ack(2'b01);
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h01, 2'b00, 0);
    apply_stimulus(2'b01, 8'h00, 2'b01, 0);
    check_output(2'b01, "tp3_err");
    check_val("tp3_err2_lit", 32'(bus3.sync_err_count), 2);

    // Inter-byte timeout.
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h04, 2'b00, 60);
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h01, 2'b00, 0);
    apply_stimulus(2'b01, 8'h01, 2'b00, 0);
    check_output(2'b01, "tp4");
    check_val("tp4_x_lit", 32'(bus3.mouse_x), 62);
    check_val("tp4_y_lit", 32'(bus3.mouse_y), 56);
    check_val("tp4_err_lit", 32'(bus3.sync_err_count), 3);
    do_ack(2'b01);

    // Wheel packet and overflow suppression on the 4-byte instance.
    apply_stimulus(2'b10, 8'h0C, 2'b00, 0);
    apply_stimulus(2'b10, 8'h00, 2'b00, 0);
    apply_stimulus(2'b10, 8'h00, 2'b00, 0);
    apply_stimulus(2'b10, 8'h0F, 2'b00, 0);
    check_output(2'b10, "tp5_wheel");
    check_val("tp5_z_lit", 32'(bus4.mouse_z), 255);
    check_val("tp5_btn_lit", 32'(bus4.mouse_buttons), 4);
    do_ack(2'b10);
    apply_stimulus(2'b10, 8'h48, 2'b00, 0);
    apply_stimulus(2'b10, 8'h50, 2'b00, 0);
    apply_stimulus(2'b10, 8'h00, 2'b00, 0);
    apply_stimulus(2'b10, 8'h00, 2'b00, 0);
    check_output(2'b10, "tp5_ovf");
    check_val("tp5_ovf_lit", 32'(bus4.mouse_x), 80);
    do_ack(2'b10);

    // Acknowledge arriving on the update edge loses to the new interrupt.
    apply_stimulus(2'b01, 8'h08, 2'b00, 0);
    apply_stimulus(2'b01, 8'h01, 2'b00, 0);
    apply_stimulus(2'b01, 8'h00, 2'b00, 0);
    bus3.interrupt_ack = 1'b1;
    @(posedge clk);
    #1;
    bus3.interrupt_ack = 1'b0;
    check_val("tp6_collide_lit", 32'(bus3.send_interrupt), 1);
    check_output(2'b01, "tp6_collide");
    do_ack(2'b01);

    // Reset in the middle of a packet.
    apply_stimulus(2'b11, 8'h08, 2'b00, 0);
    apply_stimulus(2'b11, 8'h05, 2'b00, 0);
    do_reset();
    check_output(2'b11, "tp6_rst");
    apply_stimulus(2'b11, 8'h08, 2'b00, 0);
    apply_stimulus(2'b11, 8'h05, 2'b00, 0);
    apply_stimulus(2'b11, 8'h03, 2'b00, 0);
    apply_stimulus(2'b10, 8'h00, 2'b00, 0);
    check_output(2'b11, "tp6_after");
    check_val("tp6_after_lit", 32'(bus3.mouse_x), 85);
    do_ack(2'b11);

    // Random byte stream to both instances.
    $display("[TB] random phase");
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 99));
      rb = 8'($urandom);
      if (r < 60) rb[3] = 1'b1;
      re = (r < 5) ? 2'($urandom_range(1, 3)) : 2'b00;
      rg = (r >= 97) ? 55 : int'($urandom_range(0, 2));
      apply_stimulus(2'b11, rb, re, rg);
      if ((n % 8) == 7) begin
        check_output(2'b11, "rand");
        if ($urandom_range(0, 1) == 1) do_ack(2'b11);
      end
    end

    // Sync error count saturates at 255.
    for (int n = 0; n < 260; n++) begin
      apply_stimulus(2'b11, 8'h00, 2'b00, 0);
    end
    check_output(2'b11, "sat");
    check_val("sat3_lit", 32'(bus3.sync_err_count), 255);
    check_val("sat4_lit", 32'(bus4.sync_err_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
